// File: rtl/vga_sync_receiver_if.sv
// vga_sync_receiver_if: VGA sync link into the receiver plus the recovered timing it produces.
//   p_tick, hsync_in, vsync_in            : sync generator side -> receiver
//   pixel_x, pixel_y, video_on, locked,
//   frame_start, line_err, err_count      : receiver -> monitor side
// Modports: master = generator/monitor side, slave = receiver side.
interface vga_sync_receiver_if;
  logic        p_tick;
  logic        hsync_in;
  logic        vsync_in;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        locked;
  logic        frame_start;
  logic        line_err;
  logic [15:0] err_count;

  modport master (
    output p_tick, hsync_in, vsync_in,
    input  pixel_x, pixel_y, video_on, locked, frame_start, line_err, err_count
  );

  modport slave (
    input  p_tick, hsync_in, vsync_in,
    output pixel_x, pixel_y, video_on, locked, frame_start, line_err, err_count
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers pixel position, video_on and lock from a VGA hsync/vsync pair,
// verifying line and frame lengths against the nominal timing.
// Ports:
//   clk   - 50 MHz system clock (same clock as the sync generator)
//   reset - asynchronous, active-high reset
//   bus   - vga_sync_receiver_if.slave: p_tick/hsync_in/vsync_in in; pixel_x, pixel_y,
//           video_on, locked, frame_start, line_err, err_count out
// Build option: define ERR_COUNT_EN to include the saturating line_err counter on err_count;
// otherwise err_count is tied to zero.
module vga_sync_receiver #(
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned H_DISP       = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned V_DISP       = 480,
  parameter int unsigned V_SYNC_START = 513,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input  logic               clk,
  input  logic               reset,
  vga_sync_receiver_if.slave bus
);

  localparam int unsigned XW = 10;
  localparam int unsigned LW = 11;
  localparam int unsigned EW = 16;
  localparam int unsigned GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_hs_sync, r_vs_sync;
  logic          r_hs_prev, r_vs_prev;
  logic [XW-1:0] r_x_cnt, r_y_cnt;
  logic [LW-1:0] r_len_cnt;
  logic [LW-1:0] r_line_cnt;
  logic [GW-1:0] r_good_cnt;
  logic          r_armed, r_frame_bad;
  logic          r_locked, r_video_on, r_frame_start, r_line_err;

  logic          w_hs, w_vs, w_h_rise, w_v_rise, w_checking;
  logic          w_line_bad, w_frame_bad, w_err, w_frame_fail, w_timeout, w_lock_go;
  logic          w_x_wrap, w_locked_nxt, w_video_nxt;
  logic [LW-1:0] w_lines_seen;
  logic [XW-1:0] w_x_nxt, w_y_nxt;

  // Edge detection, length checks and next-value computation for the timing counters.
  always_comb begin
    w_hs       = r_hs_sync[1];
    w_vs       = r_vs_sync[1];
    w_h_rise   = bus.p_tick & w_hs & ~r_hs_prev;
    w_v_rise   = bus.p_tick & w_vs & ~r_vs_prev;
    w_checking = (r_state != ST_SEARCH);

    w_line_bad   = w_h_rise & w_checking & ((r_len_cnt + LW'(1)) != LW'(H_TOTAL));
    // A coincident h-rise is counted into the frame that is ending.
    w_lines_seen = r_line_cnt + LW'(w_h_rise);
    // The partial frame seen right after leaving SEARCH only arms the frame check.
    w_frame_bad  = w_v_rise & w_checking & r_armed & (w_lines_seen != LW'(V_TOTAL));
    w_err        = w_line_bad | w_frame_bad;
    w_frame_fail = r_frame_bad | w_err;
    w_timeout    = bus.p_tick & ~w_h_rise & (r_len_cnt >= LW'(2 * H_TOTAL));
    w_lock_go    = (r_state == ST_ACQUIRE) & w_v_rise & r_armed & ~w_frame_fail &
                   (r_good_cnt == GW'(LOCK_FRAMES - 1));

    w_locked_nxt = 1'b0;
    if (!w_timeout) begin
      if (r_state == ST_LOCKED) w_locked_nxt = ~w_err;
      else if (w_lock_go)       w_locked_nxt = 1'b1;
    end

    w_x_wrap = 1'b0;
    w_x_nxt  = r_x_cnt;
    if (bus.p_tick) begin
      if (w_h_rise) begin
        w_x_nxt = XW'(H_SYNC_START);
      end else if (r_x_cnt == XW'(H_TOTAL - 1)) begin
        w_x_nxt  = '0;
        w_x_wrap = 1'b1;
      end else begin
        w_x_nxt = r_x_cnt + XW'(1);
      end
    end

    w_y_nxt = r_y_cnt;
    if (w_v_rise) begin
      w_y_nxt = XW'(V_SYNC_START);
    end else if (w_x_wrap) begin
      w_y_nxt = (r_y_cnt == XW'(V_TOTAL - 1)) ? '0 : r_y_cnt + XW'(1);
    end

    w_video_nxt = w_locked_nxt & (w_x_nxt < XW'(H_DISP)) & (w_y_nxt < XW'(V_DISP));
  end

  // Synchronisers, counters, lock FSM and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_SEARCH;
      r_hs_sync     <= '0;
      r_vs_sync     <= '0;
      r_hs_prev     <= 1'b0;
      r_vs_prev     <= 1'b0;
      r_x_cnt       <= '0;
      r_y_cnt       <= '0;
      r_len_cnt     <= '0;
      r_line_cnt    <= '0;
      r_good_cnt    <= '0;
      r_armed       <= 1'b0;
      r_frame_bad   <= 1'b0;
      r_locked      <= 1'b0;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_err    <= 1'b0;
    end else begin
      r_hs_sync     <= {r_hs_sync[0], bus.hsync_in};
      r_vs_sync     <= {r_vs_sync[0], bus.vsync_in};
      r_x_cnt       <= w_x_nxt;
      r_y_cnt       <= w_y_nxt;
      r_frame_start <= w_v_rise;
      r_line_err    <= w_err;
      r_locked      <= w_locked_nxt;
      r_video_on    <= w_video_nxt;

      if (bus.p_tick) begin
        r_hs_prev <= w_hs;
        r_vs_prev <= w_vs;
        if (w_h_rise)              r_len_cnt <= '0;
        else if (r_len_cnt != '1) r_len_cnt <= r_len_cnt + LW'(1);
        if (w_v_rise)                           r_line_cnt <= '0;
        else if (w_h_rise && r_line_cnt != '1) r_line_cnt <= r_line_cnt + LW'(1);
        // Remembers a bad line until the frame it belongs to is judged.
        if (w_v_rise)        r_frame_bad <= 1'b0;
        else if (w_line_bad) r_frame_bad <= 1'b1;
      end

      case (r_state)
        ST_SEARCH: begin
          if (w_h_rise) begin
            r_state    <= ST_ACQUIRE;
            r_good_cnt <= '0;
            r_armed    <= 1'b0;
          end
        end
        ST_ACQUIRE: begin
          if (w_timeout) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= '0;
            r_armed    <= 1'b0;
          end else if (w_v_rise) begin
            if (!r_armed) begin
              r_armed <= 1'b1;
            end else if (w_frame_fail) begin
              r_good_cnt <= '0;
            end else if (w_lock_go) begin
              r_state    <= ST_LOCKED;
              r_good_cnt <= GW'(LOCK_FRAMES);
            end else begin
              r_good_cnt <= r_good_cnt + GW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (w_timeout) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= '0;
            r_armed    <= 1'b0;
          end else if (w_err) begin
            r_state    <= ST_ACQUIRE;
            r_good_cnt <= '0;
          end
        end
        default: r_state <= ST_SEARCH;
      endcase
    end
  end

`ifdef ERR_COUNT_EN
  logic [EW-1:0] r_err_count;

  // Saturating count of line_err pulses; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_err_count <= '0;
    else if (w_err && r_err_count != '1) r_err_count <= r_err_count + EW'(1);
  end

  assign bus.err_count = r_err_count;
`else
  assign bus.err_count = EW'(0);
`endif

  assign bus.pixel_x     = r_x_cnt;
  assign bus.pixel_y     = r_y_cnt;
  assign bus.video_on    = r_video_on;
  assign bus.locked      = r_locked;
  assign bus.frame_start = r_frame_start;
  assign bus.line_err    = r_line_err;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: drives vga_sync_receiver from a small sync generator model.
// Scaled-down geometry (40x12 ticks) keeps each frame short; the receiver is fully parameterised.
`timescale 1ns/1ps
module tb_vga_sync_receiver;
  localparam int unsigned HT  = 40;
  localparam int unsigned HD  = 32;
  localparam int unsigned HSS = 34;
  localparam int unsigned HSW = 4;
  localparam int unsigned VT  = 12;
  localparam int unsigned VD  = 8;
  localparam int unsigned VSS = 9;
  localparam int unsigned VSW = 2;
  localparam int unsigned LF  = 2;
  localparam int unsigned FT  = HT * VT;
`ifdef ERR_COUNT_EN
  localparam int unsigned EC_EN = 1;
`else
  localparam int unsigned EC_EN = 0;
`endif

  logic clk = 1'b0;
  logic reset;

  vga_sync_receiver_if vif ();

  vga_sync_receiver #(
    .H_TOTAL(HT), .H_DISP(HD), .H_SYNC_START(HSS),
    .V_TOTAL(VT), .V_DISP(VD), .V_SYNC_START(VSS), .LOCK_FRAMES(LF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  always #10 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned gx, gy;
  int          h_sup;
  bit          stretch_req, short_req;
  int          fs_seen, le_seen, von_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clk: sample DUT events at the falling edge, then step the generator and drive inputs.
  task automatic tick();
    @(negedge clk);
    if (vif.frame_start === 1'b1) fs_seen++;
    if (vif.line_err === 1'b1)    le_seen++;
    if (vif.video_on === 1'b1)    von_seen++;
    if (vif.p_tick) begin
      if (stretch_req && gx == 20) begin
        stretch_req = 1'b0;
      end else if (gx == HT - 1) begin
        gx = 0;
        if (short_req && gy == VT - 2) begin
          gy = 0;
          short_req = 1'b0;
        end else begin
          gy = (gy == VT - 1) ? 0 : gy + 1;
        end
      end else begin
        gx = gx + 1;
      end
      if (h_sup > 0) h_sup--;
    end
    vif.hsync_in = (h_sup == 0) && (gx >= HSS) && (gx < HSS + HSW);
    vif.vsync_in = (gy >= VSS) && (gy < VSS + VSW);
    vif.p_tick   = ~vif.p_tick;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_fs(input string tag);
    int target;
    int budget;
    target = fs_seen + 1;
    budget = 4 * FT + 100;
    while (fs_seen < target && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, "_fs"}, 32'(fs_seen), 32'(target));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_px"},  32'(vif.pixel_x),     0);
    check({tag, "_py"},  32'(vif.pixel_y),     0);
    check({tag, "_von"}, 32'(vif.video_on),    0);
    check({tag, "_lck"}, 32'(vif.locked),      0);
    check({tag, "_fs"},  32'(vif.frame_start), 0);
    check({tag, "_le"},  32'(vif.line_err),    0);
    check({tag, "_ec"},  32'(vif.err_count),   0);
  endtask

  // Locked receiver position lags the generator by two pixel ticks.
  task automatic check_track(input string tag);
    int unsigned e;
    e = (gy * HT + gx + FT - 2) % FT;
    check({tag, "_x"},   32'(vif.pixel_x),  e % HT);
    check({tag, "_y"},   32'(vif.pixel_y),  e / HT);
    check({tag, "_von"}, 32'(vif.video_on), 32'((e % HT < HD) && (e / HT < VD)));
  endtask

  task automatic expect_relock(input string tag);
    wait_fs({tag, "1"});
    check({tag, "1_lck"}, 32'(vif.locked), 0);
    wait_fs({tag, "2"});
    check({tag, "2_lck"}, 32'(vif.locked), 0);
    wait_fs({tag, "3"});
    check({tag, "3_lck"}, 32'(vif.locked), 1);
  endtask

  initial begin
    gx = 0; gy = 0; h_sup = 0;
    stretch_req = 1'b0; short_req = 1'b0;
    fs_seen = 0; le_seen = 0; von_seen = 0;
    vif.p_tick = 1'b0; vif.hsync_in = 1'b0; vif.vsync_in = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset = 1'b0;

    // Nominal timing: lock on the third v-rise, no errors.
    expect_relock("acq");
    check("nom_le", 32'(le_seen), 0);
    check("nom_ec", 32'(vif.err_count), 0);

    // One full frame of position tracking and video_on coverage.
    von_seen = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      tick();
      if (i % 13 == 0) check_track("trk");
    end
    check("von_cnt", 32'(von_seen), 2 * HD * VD);
    check("trk_le", 32'(le_seen), 0);

    // One line stretched by a tick while locked.
    stretch_req = 1'b1;
    for (int b = 0; b < 4 * FT && stretch_req; b++) tick();
    run(4 * HT);
    check("str_le",  32'(le_seen), 1);
    check("str_lck", 32'(vif.locked), 0);
    check("str_ec",  32'(vif.err_count), EC_EN);
    expect_relock("str");
    check("str_le_end", 32'(le_seen), 1);

    // A frame one line short while locked.
    short_req = 1'b1;
    wait_fs("short");
    check("short_le_pulse", 32'(vif.line_err), 1);
    check("short_le", 32'(le_seen), 2);
    run(4);
    check("short_lck", 32'(vif.locked), 0);
    check("short_ec",  32'(vif.err_count), 2 * EC_EN);
    wait_fs("sh1");
    check("sh1_lck", 32'(vif.locked), 0);
    wait_fs("sh2");
    check("sh2_lck", 32'(vif.locked), 1);

    // hsync held low for several lines: back to SEARCH, then re-acquire.
    for (int b = 0; b < 4 * FT && !(gx == 0 && gy == 0); b++) tick();
    h_sup = 3 * HT;
    run(10 * HT);
    check("to_lck", 32'(vif.locked), 0);
    check("to_le",  32'(le_seen), 2);
    expect_relock("to");
    check("to_le_end", 32'(le_seen), 2);

    // Asynchronous reset mid-frame while locked.
    run(300);
    check("pre_rst_lck", 32'(vif.locked), 1);
    reset = 1'b1;
    #1;
    check_zero("arst");
    run(20);
    check_zero("arst_hold");
    reset = 1'b0;
    expect_relock("rr");
    check("end_le", 32'(le_seen), 2);
    check("end_ec", 32'(vif.err_count), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
